round_robin_fifo_dispatcher: RTL and testbench

- Opposite direction of the round-robin FIFO arbiter: one producer stream in, four per-lane FIFOs out.
- Each accepted input word goes to one of four lane FIFOs, in round-robin order.
- Four consumers drain their own lanes independently with per-lane read enables.
- Sits between a single upstream source and four downstream units.

---
 rtl/round_robin_fifo_dispatcher.sv | 121 ++++++++++++
 tb/tb_round_robin_fifo_dispatcher.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_fifo_dispatcher.sv
// Round-robin dispatcher: one input stream spread over four independent lane FIFOs.
// Optional macro DISPATCH_SKIP_FULL_EN lets the input skip full lanes instead of stalling.
module round_robin_fifo_dispatcher #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    ren,
  output logic [DW-1:0] dout_a,
  output logic [DW-1:0] dout_b,
  output logic [DW-1:0] dout_c,
  output logic [DW-1:0] dout_d,
  output logic [3:0]    valid,
  output logic [3:0]    full,
  output logic [3:0]    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem    [4][DEPTH];
  logic [AW-1:0] wptr   [4];
  logic [AW-1:0] rptr   [4];
  logic [AW:0]   cnt    [4];
  logic [DW-1:0] dout_r [4];

  logic [1:0] ptr;
  logic [1:0] target;
  logic       accept;
  logic [3:0] we;
  logic [3:0] rd;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      full[i]  = (cnt[i] == DEPTH_CNT);
      empty[i] = (cnt[i] == '0);
    end
  end

`ifdef DISPATCH_SKIP_FULL_EN
  logic       found;
  logic [1:0] idx;

  // First non-full lane in rotation order starting at ptr.
  always_comb begin
    target = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      idx = ptr + 2'(j);
      if (!found && !full[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
    in_ready = ~&full;
  end
`else
  always_comb begin
    target   = ptr;
    in_ready = !full[ptr];
  end
`endif

  always_comb begin
    accept = in_valid && in_ready;
    we     = '0;
    rd     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      we[i] = accept && (target == 2'(i));
      rd[i] = ren[i] && !empty[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      valid <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        wptr[i]   <= '0;
        rptr[i]   <= '0;
        cnt[i]    <= '0;
        dout_r[i] <= '0;
      end
    end else begin
      if (accept)
        ptr <= target + 2'd1;
      valid <= rd;
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i])
          wptr[i] <= wptr[i] + 1'b1;
        if (rd[i])
          rptr[i] <= rptr[i] + 1'b1;
        // Pre-edge counts gate both sides, so a simultaneous read+write nets to zero.
        cnt[i]    <= cnt[i] + (AW+1)'(we[i]) - (AW+1)'(rd[i]);
        dout_r[i] <= rd[i] ? mem[i][rptr[i]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i])
          mem[i][wptr[i]] <= din;
      end
    end
  end

  assign dout_a = dout_r[0];
  assign dout_b = dout_r[1];
  assign dout_c = dout_r[2];
  assign dout_d = dout_r[3];

endmodule

// File: tb/tb_round_robin_fifo_dispatcher.sv
// Directed self-checking bench for round_robin_fifo_dispatcher (DW=8, DEPTH=8).
module tb_round_robin_fifo_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ren;
  logic [7:0] dout_a, dout_b, dout_c, dout_d;
  logic [3:0] valid, full, empty;

  int tests  = 0;
  int errors = 0;

  round_robin_fifo_dispatcher #(.DW(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .ren(ren), .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c), .dout_d(dout_d),
    .valid(valid), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; din = '0; ren = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d);
    in_valid = 1'b1; din = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (valid !== 4'b0000 || empty !== 4'b1111 || full !== 4'b0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: valid=%b empty=%b full=%b in_ready=%b, want 0000 1111 0000 1",
               valid, empty, full, in_ready);
    end
    tests++;
    if (dout_a !== 8'd0 || dout_b !== 8'd0 || dout_c !== 8'd0 || dout_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_dout: %h %h %h %h, want all 00", dout_a, dout_b, dout_c, dout_d);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    write_word(8'd10); write_word(8'd20); write_word(8'd30);
    write_word(8'd40); write_word(8'd50);
    tests++;
    if (empty !== 4'b0000) begin
      errors++; $display("FAIL rot_empty: got %b want 0000", empty);
    end
    ren = 4'b1111;
    tick();
    tests++;
    if (dout_a !== 8'd10 || dout_b !== 8'd20 || dout_c !== 8'd30 || dout_d !== 8'd40 || valid !== 4'b1111) begin
      errors++;
      $display("FAIL rot_read_all: a=%0d b=%0d c=%0d d=%0d valid=%b, want 10 20 30 40 1111",
               dout_a, dout_b, dout_c, dout_d, valid);
    end
    ren = 4'b0001;
    tick();
    tests++;
    if (dout_a !== 8'd50 || valid !== 4'b0001 || dout_b !== 8'd0) begin
      errors++;
      $display("FAIL rot_read_a: a=%0d b=%0d valid=%b, want 50 0 0001", dout_a, dout_b, valid);
    end
    ren = 4'b0000;
    tick();
    tests++;
    if (valid !== 4'b0000 || dout_a !== 8'd0 || empty !== 4'b1111) begin
      errors++;
      $display("FAIL rot_idle: valid=%b a=%0d empty=%b, want 0000 0 1111", valid, dout_a, empty);
    end
  endtask

  task automatic test_read_empty();
    do_reset();
    ren = 4'b0010;
    tick();
    ren = 4'b0000;
    tests++;
    if (valid !== 4'b0000 || dout_b !== 8'd0 || empty !== 4'b1111) begin
      errors++;
      $display("FAIL read_empty: valid=%b b=%0d empty=%b, want 0000 0 1111", valid, dout_b, empty);
    end
  endtask

  task automatic fill_all();
    for (int i = 0; i < 32; i++) write_word(8'(i + 1));
  endtask

  task automatic test_full();
    logic [7:0] exp_a [8];
    do_reset();
    fill_all();
    tests++;
    if (full !== 4'b1111 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_all: full=%b in_ready=%b, want 1111 0", full, in_ready);
    end
    ren = 4'b0001;
    tick();
    ren = 4'b0000;
    tests++;
    if (dout_a !== 8'd1 || full !== 4'b1110 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_a: a=%0d full=%b in_ready=%b, want 1 1110 1", dout_a, full, in_ready);
    end
    // 32 writes leave the rotation back at lane a, so both modes land here.
    write_word(8'd99);
    tests++;
    if (full !== 4'b1111) begin
      errors++; $display("FAIL full_refill_a: full=%b want 1111", full);
    end
    exp_a = '{8'd5, 8'd9, 8'd13, 8'd17, 8'd21, 8'd25, 8'd29, 8'd99};
    ren = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (dout_a !== exp_a[i] || valid !== 4'b0001) begin
        errors++;
        $display("FAIL full_drain_a[%0d]: a=%0d valid=%b, want %0d 0001", i, dout_a, valid, exp_a[i]);
      end
    end
    ren = 4'b0000;
    tests++;
    if (empty !== 4'b0001) begin
      errors++; $display("FAIL full_drained: empty=%b want 0001", empty);
    end
  endtask

  task automatic test_full_target_stall();
    logic       exp_ready;
    logic [3:0] exp_full;
`ifdef DISPATCH_SKIP_FULL_EN
    exp_ready = 1'b1; exp_full = 4'b1111;
`else
    exp_ready = 1'b0; exp_full = 4'b1101;
`endif
    do_reset();
    fill_all();
    ren = 4'b0010;
    tick();
    ren = 4'b0000;
    tests++;
    if (dout_b !== 8'd2 || full !== 4'b1101 || in_ready !== exp_ready) begin
      errors++;
      $display("FAIL stall_pop_b: b=%0d full=%b in_ready=%b, want 2 1101 %b", dout_b, full, in_ready, exp_ready);
    end
    write_word(8'hAB);
    tests++;
    if (full !== exp_full) begin
      errors++; $display("FAIL stall_write: full=%b want %b", full, exp_full);
    end
  endtask

  task automatic test_same_lane_rw();
    do_reset();
    write_word(8'd1);
    write_word(8'd2);
    in_valid = 1'b1; din = 8'd77; ren = 4'b0100;
    tick();
    in_valid = 1'b0; ren = 4'b0000;
    tests++;
    if (valid !== 4'b0000 || dout_c !== 8'd0 || empty !== 4'b1000) begin
      errors++;
      $display("FAIL rw_empty_lane: valid=%b c=%0d empty=%b, want 0000 0 1000", valid, dout_c, empty);
    end
    ren = 4'b0100;
    tick();
    ren = 4'b0000;
    tests++;
    if (dout_c !== 8'd77 || valid !== 4'b0100 || empty !== 4'b1100) begin
      errors++;
      $display("FAIL rw_read_c: c=%0d valid=%b empty=%b, want 77 0100 1100", dout_c, valid, empty);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    write_word(8'd11); write_word(8'd12); write_word(8'd13);
    rst = 1'b1; ren = 4'b1111; in_valid = 1'b1; din = 8'd66;
    tick();
    rst = 1'b0; ren = 4'b0000; in_valid = 1'b0;
    tests++;
    if (valid !== 4'b0000 || empty !== 4'b1111 || full !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_flags: valid=%b empty=%b full=%b, want 0000 1111 0000", valid, empty, full);
    end
    write_word(8'd5);
    tests++;
    if (empty !== 4'b1110) begin
      errors++; $display("FAIL midrst_lane: empty=%b want 1110", empty);
    end
    ren = 4'b0001;
    tick();
    ren = 4'b0000;
    tests++;
    if (dout_a !== 8'd5 || valid !== 4'b0001) begin
      errors++; $display("FAIL midrst_read: a=%0d valid=%b, want 5 0001", dout_a, valid);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0; ren = '0;
    test_reset();
    test_rotation();
    test_read_empty();
    test_full();
    test_full_target_stall();
    test_same_lane_rw();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
